// File: rtl/ap_txn_profiler_pkg.sv
// Shared types for the ap_ctrl transaction profiler: FSM states, start-queue
// entries and output records.
package ap_prof_pkg;

    localparam int TS_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } prof_state_e;

    typedef struct packed {
        logic [TS_W-1:0] ts;
        logic [TS_W-1:0] ii;
        logic            first;
    } start_ent_t;

    typedef struct packed {
        logic [TS_W-1:0] start_ts;
        logic [TS_W-1:0] latency;
        logic [TS_W-1:0] ii;
        logic            first;
    } rec_t;

endpackage

// File: rtl/ap_txn_profiler_if.sv
// Observed ap_ctrl handshake plus the outgoing record stream.
// Record stream: a record transfers on every rising clock edge where rec_valid
// and rec_ready are both 1; rec_valid never depends on rec_ready, and rec_*
// data stays stable while rec_valid=1 and rec_ready=0.
interface ap_txn_profiler_if #(
    parameter int TS_W = ap_prof_pkg::TS_W
) ();
    logic            ap_start;
    logic            ap_ready;
    logic            ap_done;
    logic            ap_continue;
    logic            rec_valid;
    logic            rec_ready;
    logic [TS_W-1:0] rec_start_ts;
    logic [TS_W-1:0] rec_latency;
    logic [TS_W-1:0] rec_ii;
    logic            rec_first;

    modport master (
        output ap_start, ap_ready, ap_done, ap_continue, rec_ready,
        input  rec_valid, rec_start_ts, rec_latency, rec_ii, rec_first
    );

    modport slave (
        input  ap_start, ap_ready, ap_done, ap_continue, rec_ready,
        output rec_valid, rec_start_ts, rec_latency, rec_ii, rec_first
    );
endinterface

// File: rtl/prof_sync_fifo.sv
// Synchronous FIFO; a push while full is accepted when a pop happens in the
// same cycle.
module prof_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/ap_txn_profiler.sv
// Timestamps ap_ctrl start acceptances and completions, pairs them in order and
// emits one {start_ts, latency, ii, first} record per transaction.
module ap_txn_profiler #(
    parameter int TS_W        = ap_prof_pkg::TS_W,
    parameter int OUTSTANDING = 4,
    parameter int OUT_DEPTH   = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    ap_txn_profiler_if.slave         bus,
    input  logic                     finish,
    output logic [15:0]              drop_cnt,
    output logic                     err_overrun,
    output logic                     err_orphan,
    output logic                     all_done,
    output ap_prof_pkg::prof_state_e state
);
    import ap_prof_pkg::*;

    prof_state_e     state_nxt;
    logic [TS_W-1:0] cyc;
    logic [TS_W-1:0] prev_start;
    logic            seen_start;

    logic       start_ev, done_ev, bypass, overrun, orphan, accept, rec_form, rec_drop;
    start_ent_t new_ent, src_ent, sq_dout;
    rec_t       rec_din, rf_dout;
    logic       sq_push, sq_pop, sq_full, sq_empty;
    logic       rf_push, rf_pop, rf_full, rf_empty;

    assign start_ev = bus.ap_start & bus.ap_ready & ((state == IDLE) | (state == RUN));
    assign done_ev  = bus.ap_done & bus.ap_continue & (state != DONE);

    always_comb begin
        new_ent.ts    = cyc;
        new_ent.first = ~seen_start;
        new_ent.ii    = seen_start ? (cyc - prev_start) : '0;

        // An empty queue lets a same-cycle done consume the concurrent start.
        bypass   = start_ev & done_ev & sq_empty;
        overrun  = start_ev & sq_full & ~done_ev;
        accept   = start_ev & ~overrun;
        orphan   = done_ev & sq_empty & ~start_ev;
        sq_push  = accept & ~bypass;
        sq_pop   = done_ev & ~sq_empty;
        rec_form = done_ev & (bypass | ~sq_empty);

        src_ent          = bypass ? new_ent : sq_dout;
        rec_din.start_ts = src_ent.ts;
        rec_din.latency  = cyc - src_ent.ts;
        rec_din.ii       = src_ent.ii;
        rec_din.first    = src_ent.first;

        rf_pop   = ~rf_empty & bus.rec_ready;
        rf_push  = rec_form & (~rf_full | rf_pop);
        rec_drop = rec_form & rf_full & ~rf_pop;
    end

    prof_sync_fifo #(.W($bits(start_ent_t)), .DEPTH(OUTSTANDING)) u_start_q (
        .clock(clock), .reset(reset),
        .push(sq_push), .din(new_ent), .pop(sq_pop), .dout(sq_dout),
        .full(sq_full), .empty(sq_empty)
    );

    prof_sync_fifo #(.W($bits(rec_t)), .DEPTH(OUT_DEPTH)) u_rec_fifo (
        .clock(clock), .reset(reset),
        .push(rf_push), .din(rec_din), .pop(rf_pop), .dout(rf_dout),
        .full(rf_full), .empty(rf_empty)
    );

    // Record data reads as zero whenever no record is presented.
    assign bus.rec_valid    = ~rf_empty;
    assign bus.rec_start_ts = rf_empty ? '0 : rf_dout.start_ts;
    assign bus.rec_latency  = rf_empty ? '0 : rf_dout.latency;
    assign bus.rec_ii       = rf_empty ? '0 : rf_dout.ii;
    assign bus.rec_first    = rf_empty ? 1'b0 : rf_dout.first;
    assign all_done         = (state == DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cyc         <= '0;
            prev_start  <= '0;
            seen_start  <= 1'b0;
            drop_cnt    <= '0;
            err_overrun <= 1'b0;
            err_orphan  <= 1'b0;
        end else begin
            cyc <= cyc + 1'b1;
            if (accept) begin
                prev_start <= cyc;
                seen_start <= 1'b1;
            end
            if ((overrun | rec_drop) && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
            if (overrun) err_overrun <= 1'b1;
            if (orphan)  err_orphan  <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (finish) state_nxt = DRAIN;
                     else if (start_ev) state_nxt = RUN;
            RUN:     if (finish) state_nxt = DRAIN;
            DRAIN:   if (sq_empty && rf_empty) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ap_txn_profiler.sv
// Directed bench for ap_txn_profiler: single, pipelined, bypass, overrun,
// back-pressure, drain/finish and asynchronous reset scenarios.
module tb_ap_txn_profiler;
    import ap_prof_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        finish;
    logic [15:0] drop_cnt;
    logic        err_overrun, err_orphan, all_done;
    prof_state_e state;

    int checks = 0;
    int errors = 0;
    int cur_cyc = 0;

    ap_txn_profiler_if #(.TS_W(32)) prof_bus ();

    ap_txn_profiler #(.TS_W(32), .OUTSTANDING(4), .OUT_DEPTH(8)) dut (
        .clock(clock), .reset(reset), .bus(prof_bus), .finish(finish),
        .drop_cnt(drop_cnt), .err_overrun(err_overrun), .err_orphan(err_orphan),
        .all_done(all_done), .state(state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cur_cyc++;
    endtask

    task automatic run_to(input int n);
        while (cur_cyc < n) tick();
    endtask

    task automatic step(input logic s, input logic d);
        prof_bus.ap_start = s;
        prof_bus.ap_done  = d;
        tick();
        prof_bus.ap_start = 1'b0;
        prof_bus.ap_done  = 1'b0;
    endtask

    task automatic do_reset();
        reset                = 1'b1;
        finish               = 1'b0;
        prof_bus.ap_start    = 1'b0;
        prof_bus.ap_ready    = 1'b1;
        prof_bus.ap_done     = 1'b0;
        prof_bus.ap_continue = 1'b1;
        prof_bus.rec_ready   = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset   = 1'b0;
        cur_cyc = 0;
    endtask

    task automatic check_rec(input string tag, input int ts, input int lat, input int ii,
                             input logic first);
        chk({tag, ".valid"}, 64'(prof_bus.rec_valid), 64'd1);
        chk({tag, ".ts"}, 64'(prof_bus.rec_start_ts), 64'(ts));
        chk({tag, ".lat"}, 64'(prof_bus.rec_latency), 64'(lat));
        chk({tag, ".ii"}, 64'(prof_bus.rec_ii), 64'(ii));
        chk({tag, ".first"}, 64'(prof_bus.rec_first), 64'(first));
    endtask

    initial begin
        finish               = 1'b0;
        prof_bus.ap_start    = 1'b0;
        prof_bus.ap_ready    = 1'b1;
        prof_bus.ap_done     = 1'b0;
        prof_bus.ap_continue = 1'b1;
        prof_bus.rec_ready   = 1'b1;
        #12;
        chk("rst.valid", 64'(prof_bus.rec_valid), 64'd0);
        chk("rst.ts", 64'(prof_bus.rec_start_ts), 64'd0);
        chk("rst.drop", 64'(drop_cnt), 64'd0);
        chk("rst.flags", 64'({err_overrun, err_orphan, all_done}), 64'd0);
        chk("rst.state", 64'(state), 64'(IDLE));

        // Single transaction: start at 5, done at 12.
        do_reset();
        run_to(5);
        step(1'b1, 1'b0);
        chk("single.state", 64'(state), 64'(RUN));
        run_to(12);
        chk("single.pre_valid", 64'(prof_bus.rec_valid), 64'd0);
        step(1'b0, 1'b1);
        check_rec("single", 5, 7, 0, 1'b1);
        tick();
        chk("single.popped", 64'(prof_bus.rec_valid), 64'd0);

        // Pipelined at II=2.
        do_reset();
        run_to(10); step(1'b1, 1'b0);
        run_to(12); step(1'b1, 1'b0);
        run_to(14); step(1'b1, 1'b0);
        run_to(20); step(1'b0, 1'b1);
        check_rec("pipe0", 10, 10, 0, 1'b1);
        run_to(22); step(1'b0, 1'b1);
        check_rec("pipe1", 12, 10, 2, 1'b0);
        run_to(24); step(1'b0, 1'b1);
        check_rec("pipe2", 14, 10, 2, 1'b0);

        // Same-cycle start and done with an empty queue.
        do_reset();
        run_to(3);
        step(1'b1, 1'b1);
        check_rec("bypass", 3, 0, 0, 1'b1);
        chk("bypass.flags", 64'({err_overrun, err_orphan}), 64'd0);

        // Overrun: fifth start with four in flight is dropped.
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            run_to(k);
            step(1'b1, 1'b0);
        end
        chk("ovr.flag", 64'(err_overrun), 64'd1);
        chk("ovr.drop", 64'(drop_cnt), 64'd1);
        chk("ovr.orphan", 64'(err_orphan), 64'd0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1);
            check_rec($sformatf("ovr%0d", k), 1 + k, 5, (k == 0) ? 0 : 1, k == 0);
        end
        tick();
        chk("ovr.empty", 64'(prof_bus.rec_valid), 64'd0);

        // Back-pressure: nine completions into an eight-deep FIFO.
        do_reset();
        prof_bus.rec_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            run_to(k);
            step(1'b1, 1'b1);
        end
        chk("bp.drop", 64'(drop_cnt), 64'd1);
        chk("bp.flags", 64'({err_overrun, err_orphan}), 64'd0);
        prof_bus.rec_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            check_rec($sformatf("bp%0d", j), 1 + j, 0, (j == 0) ? 0 : 1, j == 0);
            tick();
        end
        chk("bp.empty", 64'(prof_bus.rec_valid), 64'd0);

        // Finish with two in flight, drain, then terminal DONE.
        do_reset();
        run_to(2);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        finish = 1'b1;
        tick();
        chk("drain.state", 64'(state), 64'(DRAIN));
        chk("drain.all_done0", 64'(all_done), 64'd0);
        step(1'b1, 1'b0);
        chk("drain.ign_start", 64'({err_overrun, drop_cnt}), 64'd0);
        run_to(7);
        step(1'b0, 1'b1);
        check_rec("drain0", 2, 5, 0, 1'b1);
        step(1'b0, 1'b1);
        check_rec("drain1", 3, 5, 1, 1'b0);
        tick();
        chk("drain.empty", 64'(prof_bus.rec_valid), 64'd0);
        chk("drain.all_done1", 64'(all_done), 64'd0);
        tick();
        chk("done.all_done", 64'(all_done), 64'd1);
        chk("done.state", 64'(state), 64'(DONE));
        step(1'b0, 1'b1);
        chk("done.orphan", 64'(err_orphan), 64'd0);
        chk("done.valid", 64'(prof_bus.rec_valid), 64'd0);
        finish = 1'b0;
        tick();
        chk("done.sticky", 64'(all_done), 64'd1);

        // Orphan done, then asynchronous reset in the middle of a drain.
        do_reset();
        prof_bus.rec_ready = 1'b0;
        run_to(1);
        step(1'b0, 1'b1);
        chk("orphan.flag", 64'(err_orphan), 64'd1);
        chk("orphan.valid", 64'(prof_bus.rec_valid), 64'd0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        finish = 1'b1;
        tick();
        chk("arst.pre_state", 64'(state), 64'(DRAIN));
        check_rec("arst.pre", 2, 0, 0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst.valid", 64'(prof_bus.rec_valid), 64'd0);
        chk("arst.ts", 64'(prof_bus.rec_start_ts), 64'd0);
        chk("arst.state", 64'(state), 64'(IDLE));
        chk("arst.flags", 64'({err_overrun, err_orphan, all_done}), 64'd0);
        finish = 1'b0;
        #10;
        reset = 1'b0;
        tick();
        tick();
        chk("arst.after_valid", 64'(prof_bus.rec_valid), 64'd0);
        chk("arst.after_state", 64'(state), 64'(IDLE));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ap_txn_profiler.md
# ap_txn_profiler

Cycle-accurate transaction profiler for one HLS block-level `ap_ctrl` interface (`ap_start`/`ap_ready`/`ap_done`/`ap_continue`). It timestamps start acceptances and completions, pairs them in order, and emits one record per transaction: start time, latency and initiation interval. It sits directly upstream of the dataflow status monitor/CSV dump stage, which consumes its record stream instead of re-deriving handshakes itself.

## Interface
- `TS_W`, 32: timestamp/latency/II width; all arithmetic is modulo 2^TS_W.
- `OUTSTANDING`, 4: depth of the in-flight start-timestamp queue (≥1).
- `OUT_DEPTH`, 8: depth of the output record FIFO (≥2).

- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `ap_start`, `ap_ready`, `ap_done`, `ap_continue`  in  1 each  observed handshake of the profiled block.
- `finish`  in  1  end of simulation/run request; level-sensitive.
- `rec_valid`  out  1  record available.
- `rec_ready`  in  1  consumer accepts record.
- `rec_start_ts`  out  TS_W  cycle of start acceptance.
- `rec_latency`  out  TS_W  done cycle minus start cycle.
- `rec_ii`  out  TS_W  start cycle minus previous start cycle; 0 when `rec_first`.
- `rec_first`  out  1  first transaction since reset.
- `drop_cnt`  out  16  saturating count of dropped starts plus dropped records.
- `err_overrun`, `err_orphan`  out  1 each  sticky error flags.
- `all_done`  out  1  profiling complete, all records drained.

## Operation
- Free-running `cyc` counter: 0 on the first cycle after reset release, +1 per cycle, wraps.
- Start event: `ap_start & ap_ready`, accepted only in IDLE/RUN. Pushes {cyc, ii, first} into the start queue; `ii = cyc - prev_start`; `prev_start` updates on every accepted start.
- Done event: `ap_done & ap_continue`. Pops the queue head and forms a record with `latency = cyc - start_ts`.
- Start and done in the same cycle with the queue empty: bypass; the done consumes the concurrent start, giving latency 0. With the queue non-empty, done pops the head and the start pushes; both succeed even when the queue is full.
- Done with the queue empty and no concurrent start: no record; `err_orphan` set.
- Start with the queue full and no concurrent done: start dropped; `err_overrun` set; `drop_cnt`+1.
- Record FIFO full at a done event with no concurrent pop: record dropped; `drop_cnt`+1. The start entry is still consumed.
- `drop_cnt` saturates at 16'hFFFF.
- Output: `rec_*` driven from the FIFO head; pop on `rec_valid & rec_ready`. Push and pop in the same cycle are always legal, including when the FIFO is full.
- FSM:
  - IDLE → RUN on the first start event.
  - IDLE or RUN → DRAIN when `finish`=1.
  - DRAIN: starts ignored and not counted; dones still processed.
  - DRAIN → DONE when the start queue and the record FIFO are both empty.
  - DONE is terminal until reset; done events in DONE are ignored.
  - `all_done`=1 only in DONE.

## Timing
- Reset values: `rec_valid`=0, `rec_*` data=0, `drop_cnt`=0, both error flags=0, `all_done`=0, state IDLE, both queues empty, `cyc`=0, `prev_start`=0.
- Reset mid-operation discards all in-flight and queued records immediately (asynchronous).
- Record latency: a done event in cycle N gives `rec_valid`=1 in cycle N+1 if the FIFO was empty.
- Error flags, `drop_cnt` and state update on the clock edge that ends the event cycle.
- `finish` sampled in cycle N: DRAIN from N+1. A start in cycle N is still accepted.
- `all_done` rises at the earliest one cycle after both queues empty.

## Structure
- Package `ap_prof_pkg`: `prof_state_e` {IDLE, RUN, DRAIN, DONE}; `start_ent_t` {ts, ii, first}; `rec_t` {start_ts, latency, ii, first}; default `TS_W`.
- Sub-module `prof_sync_fifo` (parameterised width/depth, full/empty, simultaneous push/pop when full). Instantiated twice: start queue and record FIFO. The same-cycle bypass lives in the parent.

## Test plan
- Single transaction: start at cyc 5, done at cyc 12, `rec_ready`=1 → one record {5, 7, 0, first=1}, valid at cyc 13.
- Pipelined, II=2: starts at 10/12/14, dones at 20/22/24 → latencies 10,10,10; ii 0,2,2.
- Same-cycle start+done, empty queue, at cyc 3 → record {3, 0, 0, 1}, no error.
- Overrun, OUTSTANDING=4: 5 starts, no dones → `err_overrun`=1, `drop_cnt`=1. Then 4 dones → 4 records.
- Back-pressure: `rec_ready`=0 and 9 completions with OUT_DEPTH=8 → `drop_cnt`=1. Release `rec_ready` → 8 records in order.
- Finish drain: `finish` with 2 in flight, then 2 dones → 2 records, then `all_done`=1. An orphan done afterwards leaves flags unchanged. Async reset mid-drain clears everything.
